// File: rtl/ir_key_pkg.sv
// Shared definitions for the IR key event queue: decoder button codes,
// colour encoding and the queued event record.
package ir_key_pkg;

  localparam logic [2:0] KEY_GREEN  = 3'b001;
  localparam logic [2:0] KEY_RED    = 3'b010;
  localparam logic [2:0] KEY_YELLOW = 3'b011;
  localparam logic [2:0] KEY_BLUE   = 3'b110;
  localparam logic [2:0] KEY_START  = 3'b100;

  localparam logic [1:0] COL_GREEN  = 2'd0;
  localparam logic [1:0] COL_RED    = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_BLUE   = 2'd3;

  typedef struct packed {
    logic       start;
    logic [1:0] color;
  } evt_t;

  typedef struct packed {
    logic vld;
    evt_t evt;
  } key_map_t;

  // Unknown codes come back with vld=0 and must be dropped by the caller.
  function automatic key_map_t map_key(input logic [2:0] code);
    map_key     = '0;
    map_key.vld = 1'b1;
    case (code)
      KEY_GREEN:  map_key.evt.color = COL_GREEN;
      KEY_RED:    map_key.evt.color = COL_RED;
      KEY_YELLOW: map_key.evt.color = COL_YELLOW;
      KEY_BLUE:   map_key.evt.color = COL_BLUE;
      KEY_START:  map_key.evt.start = 1'b1;
      default:    map_key.vld       = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ir_key_fifo.sv
// First-word-fall-through FIFO of 3-bit events. A push into a full FIFO
// succeeds only when a pop happens in the same cycle.
module ir_key_fifo
  import ir_key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [2:0]               wdata_i,
  output logic [2:0]               rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? 3'b000 : mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the read side masks it while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/ir_key_queue.sv
// Turns IR decoder key strobes into queued game events (colour or START).
// Define IR_KEY_HOLDOFF_EN to suppress repeat presses for HOLDOFF_CYCLES.
module ir_key_queue
  import ir_key_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int HOLDOFF_CYCLES = 12_500_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_rdy,
  input  logic [2:0]             key_code,
  input  logic                   evt_ready,
  input  logic                   clr_ovf,
  output logic                   evt_valid,
  output logic                   evt_start,
  output logic [1:0]             evt_color,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic     rdy_q, ovf_q, ovf_d;
  logic     rise, accept, pop, drop, hold_busy;
  logic     fifo_empty, fifo_full;
  logic [2:0] head;
  key_map_t km;
  evt_t     push_evt;

  // rdy_q resets high so a level already present at release is not a rise.
  assign rise     = key_rdy & ~rdy_q;
  assign km       = map_key(key_code);
  assign push_evt = km.evt;
  assign accept   = rise & km.vld & ~hold_busy;
  assign pop      = evt_valid & evt_ready;
  assign drop     = accept & fifo_full & ~pop;
  assign ovf_d    = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

`ifdef IR_KEY_HOLDOFF_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int HCW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  logic [0:0]     st_q, st_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;

  // Hold-off starts on every accepted press, including one dropped as overflow.
  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    case (st_q)
      ST_IDLE: if (accept) begin
        st_d   = ST_HOLD;
        hcnt_d = '0;
      end
      ST_HOLD: if (hcnt_q == HCW'(HOLDOFF_CYCLES - 1)) begin
        st_d   = ST_IDLE;
        hcnt_d = '0;
      end else begin
        hcnt_d = hcnt_q + HCW'(1);
      end
      default: begin
        st_d   = ST_IDLE;
        hcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      hcnt_q <= '0;
    end else begin
      st_q   <= st_d;
      hcnt_q <= hcnt_d;
    end
  end

  assign hold_busy = (st_q == ST_HOLD);
`else
  logic unused_holdoff;
  assign unused_holdoff = |HOLDOFF_CYCLES;
  assign hold_busy      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      rdy_q <= key_rdy;
      ovf_q <= ovf_d;
    end
  end

  ir_key_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (push_evt),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign evt_valid              = ~fifo_empty;
  assign {evt_start, evt_color} = head;
  assign overflow               = ovf_q;

endmodule

// File: tb/tb_ir_key_queue.sv
// Bench for ir_key_queue: queue-based event model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_ir_key_queue;
  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IR_KEY_HOLDOFF_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_rdy = 1'b0;
  logic [2:0]    key_code = 3'b000;
  logic          evt_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          evt_valid, evt_start, overflow;
  logic [1:0]    evt_color;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  ir_key_queue #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .key_rdy(key_rdy), .key_code(key_code),
    .evt_ready(evt_ready), .clr_ovf(clr_ovf), .evt_valid(evt_valid),
    .evt_start(evt_start), .evt_color(evt_color), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [2:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_prev = 1'b1;
  longint     cyc = 0;
  longint     hold_end = 0;

  function automatic bit decode(input logic [2:0] c, output logic [2:0] e);
    e = 3'b000;
    decode = 1'b1;
    if      (c == 3'b001) e = 3'b000;
    else if (c == 3'b010) e = 3'b001;
    else if (c == 3'b011) e = 3'b010;
    else if (c == 3'b110) e = 3'b011;
    else if (c == 3'b100) e = 3'b100;
    else decode = 1'b0;
  endfunction

  always @(posedge clk) begin : model
    bit rise, pop, acc, ok;
    logic [2:0] e;
    int n;
    if (rst) begin
      mq.delete();
      m_ovf    = 1'b0;
      m_prev   = 1'b1;
      hold_end = cyc;
    end else begin
      cyc++;
      rise   = key_rdy && !m_prev;
      m_prev = key_rdy;
      n      = mq.size();
      pop    = (n > 0) && evt_ready;
      ok     = decode(key_code, e);
      acc    = rise && ok && (!HOLD_EN || cyc > hold_end);
      if (acc && HOLD_EN) hold_end = cyc + HOLD;
      if (pop) void'(mq.pop_front());
      if (acc && (n < DEPTH || pop)) mq.push_back(e);
      if (acc && n == DEPTH && !pop) m_ovf = 1'b1;
      else if (clr_ovf)              m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic [CW+4:0] exp_v, act_v;
    logic [2:0] h;
    if (rst) exp_v = '0;
    else begin
      h = (mq.size() > 0) ? mq[0] : 3'b000;
      exp_v = {mq.size() > 0, h, m_ovf, CW'(mq.size())};
    end
    act_v = {evt_valid, evt_start, evt_color, overflow, fifo_count};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t {valid,start,color,ovf,count} actual=%b required=%b",
               $time, act_v, exp_v);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic press(input logic [2:0] c);
    key_code = c;
    key_rdy  = 1'b1;
    tick();
    key_rdy  = 1'b0;
    tick();
  endtask

  task automatic pop_expect(input string nm, input logic [2:0] e);
    chk({nm, "_valid"}, 32'(evt_valid), 1);
    chk({nm, "_head"}, 32'({evt_start, evt_color}), 32'(e));
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    tick();
    rst = 1'b0;
    idle(2);

    // Long key_rdy level yields a single event visible the next cycle.
    key_code = 3'b010;
    key_rdy  = 1'b1;
    chk("t1_pre_valid", 32'(evt_valid), 0);
    tick();
    chk("t1_valid", 32'(evt_valid), 1);
    chk("t1_color", 32'(evt_color), 1);
    chk("t1_start", 32'(evt_start), 0);
    chk("t1_count", 32'(fifo_count), 1);
    idle(3);
    key_rdy = 1'b0;
    tick();
    chk("t1_count_hold", 32'(fifo_count), 1);
    pop_expect("t1_pop", 3'b001);
    chk("t1_empty", 32'(fifo_count), 0);
    idle(12);

    // Hold-off: rise 3 cycles later suppressed, 10 cycles later accepted.
    press(3'b001);
    idle(1);
    press(3'b011);
    idle(5);
    press(3'b011);
    chk("t2_count", 32'(fifo_count), HOLD_EN ? 2 : 3);
    pop_expect("t2_p0", 3'b000);
    pop_expect("t2_p1", 3'b010);
    if (!HOLD_EN) pop_expect("t2_p2", 3'b010);
    chk("t2_empty", 32'(fifo_count), 0);
    idle(10);

    // Unknown code dropped and does not arm hold-off.
    press(3'b101);
    chk("t3_unknown", 32'(fifo_count), 0);
    press(3'b110);
    chk("t3_count", 32'(fifo_count), 1);
    pop_expect("t3_blue", 3'b011);
    idle(10);

    // Overflow: six presses into four slots.
    press(3'b001); idle(9);
    press(3'b010); idle(9);
    press(3'b011); idle(9);
    press(3'b110); idle(9);
    press(3'b100); idle(9);
    press(3'b001); idle(9);
    chk("t4_count", 32'(fifo_count), 4);
    chk("t4_ovf", 32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 0);
    pop_expect("t4_p0", 3'b000);
    pop_expect("t4_p1", 3'b001);
    pop_expect("t4_p2", 3'b010);
    pop_expect("t4_p3", 3'b011);
    chk("t4_empty", 32'(evt_valid), 0);
    idle(10);

    // Full FIFO with simultaneous push and pop.
    press(3'b110); idle(9);
    press(3'b100); idle(9);
    press(3'b010); idle(9);
    press(3'b001); idle(9);
    chk("t5_full", 32'(fifo_count), 4);
    key_code  = 3'b011;
    key_rdy   = 1'b1;
    evt_ready = 1'b1;
    tick();
    key_rdy   = 1'b0;
    evt_ready = 1'b0;
    chk("t5_count", 32'(fifo_count), 4);
    chk("t5_ovf", 32'(overflow), 0);
    tick();
    pop_expect("t5_p0", 3'b100);
    pop_expect("t5_p1", 3'b001);
    pop_expect("t5_p2", 3'b000);
    pop_expect("t5_p3", 3'b010);
    idle(10);

    // key_rdy high across reset release; reset during hold-off.
    key_code = 3'b001;
    key_rdy  = 1'b1;
    rst      = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
    chk("t6_no_evt", 32'(fifo_count), 0);
    key_rdy = 1'b0;
    tick();
    press(3'b001);
    chk("t6_first", 32'(fifo_count), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_count", 32'(fifo_count), 0);
    rst = 1'b0;
    tick();
    press(3'b010);
    chk("t6_after", 32'(fifo_count), 1);
    pop_expect("t6_pop", 3'b001);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        key_rdy = ~key_rdy;
        if (key_rdy) key_code = 3'($urandom_range(0, 7));
      end
      evt_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    evt_ready = 1'b0;
    clr_ovf = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_key_queue.md
Name: ir_key_queue

Overview:
- Downstream of the IR remote decoder; consumes its key-ready strobe and 3-bit key code.
- Converts each remote key press into exactly one game event: colour 0-3 or start.
- Buffers events in a small FIFO and presents them to the Genius game FSM over a valid/ready handshake.
- Optionally suppresses repeat frames of the same press with a hold-off timer.

Parameters:
- DEPTH, 4: FIFO entries. Power of two, 2..16.
- HOLDOFF_CYCLES, 12_500_000: hold-off length in clk cycles, i.e. 250 ms at 50 MHz. Minimum 1.

Ports:
- clk  in  1  system clock. Logic runs on the rising edge; the decoder drives its outputs on the falling edge, so they are stable here.
- rst  in  1  reset, asynchronous, active-high.
- key_rdy  in  1  decoder ready level; may stay high for several cycles.
- key_code  in  3  decoder button code; valid while key_rdy=1.
- evt_ready  in  1  consumer accepts the head event.
- clr_ovf  in  1  clears overflow.
- evt_valid  out  1  FIFO non-empty.
- evt_start  out  1  head event is START.
- evt_color  out  2  head colour: 0 green, 1 red, 2 yellow, 3 blue.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async): evt_valid=0, evt_start=0, evt_color=0, overflow=0, fifo_count=0, pointers=0, hold-off FSM=IDLE, counter=0.
- rdy_q resets to 1, so a key_rdy already high at reset release is not captured.
- Edge detect: rdy_q <= key_rdy every cycle; rise = key_rdy & ~rdy_q; key_code is sampled in the rise cycle.
- Code map:
  - 001 -> colour 0; 010 -> colour 1; 011 -> colour 2; 110 -> colour 3.
  - 100 -> START (evt_start=1, evt_color=0).
  - Any other code: dropped silently; does not start hold-off.
- Hold-off FSM:
  - IDLE: an accepted rise pushes the event and goes to HOLD with counter=0.
  - HOLD: counter increments each cycle; at HOLDOFF_CYCLES-1 it returns to IDLE.
  - Rises during HOLD are ignored and do not restart the counter.
  - A rise in the exact cycle HOLD exits is still ignored.
- Latency: rise in cycle N -> entry written at the end of N -> with the FIFO empty, evt_valid=1 in cycle N+1.
- FIFO: first-word-fall-through; outputs show the head entry.
  - When empty, evt_start and evt_color are driven 0.
  - Pop when evt_valid & evt_ready; evt_ready while empty is ignored.
- Full:
  - A push with no simultaneous pop is dropped: overflow <= 1, hold-off still starts.
  - Push and pop in the same cycle when full both succeed; count unchanged.
  - Push and pop in the same cycle when count=1: new entry visible next cycle; evt_valid stays 1.
- overflow: cleared by clr_ovf. If clr_ovf and a new drop occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH; fifo_count is 0..DEPTH.
- rst mid-hold-off or mid-FIFO discards everything; no event is emitted after release.

Optional Feature:
- Macro: IR_KEY_HOLDOFF_EN.
- Defined: hold-off FSM and counter as above.
- Undefined: no FSM or counter. Every valid rise is pushed; HOLDOFF_CYCLES is unused.

Decomposition:
- Package ir_key_pkg:
  - Code constants KEY_GREEN=3'b001, KEY_RED=3'b010, KEY_YELLOW=3'b011, KEY_BLUE=3'b110, KEY_START=3'b100.
  - Colour encoding constants.
  - Event struct {start, color[1:0]}.
- Sub-module ir_key_fifo: synchronous FWFT FIFO, parameter DEPTH, width 3. It owns pointers, count and full/empty. The top owns edge detect, code map, hold-off and overflow.

Test Plan (HOLDOFF_CYCLES=8, DEPTH=4):
- Code 010 with key_rdy high for 4 cycles, evt_ready=0 -> one entry; evt_valid=1 one cycle after the rise; evt_color=1, evt_start=0, fifo_count=1.
- Rise of code 001, then a rise of 011 three cycles later -> only colour 0 queued. A rise of 011 at 10 cycles -> colour 2 queued. Without the macro, both are queued.
- Code 101 -> nothing queued; an immediate 110 rise is accepted as colour 3.
- Six spaced presses with evt_ready=0 -> fifo_count=4, overflow=1. clr_ovf pulse -> overflow=0. Drain with evt_ready=1 returns the first four in order.
- Full FIFO, push and pop in the same cycle -> fifo_count stays 4, overflow stays 0, and the new event appears last.
- key_rdy high across rst deassertion -> no event. Assert rst during HOLD -> a new rise right after release is accepted.
